// File: rtl/midi_spi_pkg.sv
// rtl/midi_spi_pkg.sv - frame constants and FSM states for the SPI voice-command transmitter
package midi_spi_pkg;
  localparam logic [7:0] NOTEON        = 8'h90;
  localparam logic [7:0] NOTEOFF       = 8'h80;
  localparam logic [2:0] NOTEON_BYTES  = 3'd4;
  localparam logic [2:0] NOTEOFF_BYTES = 3'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FINISH} state_t;

  // Index of the final byte in a frame; the byte counter never goes past it.
  function automatic logic [1:0] last_index(input logic note_on);
    logic [2:0] n;
    n = note_on ? NOTEON_BYTES : NOTEOFF_BYTES;
    return 2'(n - 3'd1);
  endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - mode-0 MSB-first byte serializer, sclk and mosi straight from flops
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          active;

  // High during the final cycle of the last high half-period, so the caller can chain with no gap.
  assign byte_done = active && sclk && (div_cnt == '0) && (bit_cnt == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else if (start) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= data[7];
      shreg   <= data[6:0];
      bit_cnt <= 3'd7;
      div_cnt <= RELOAD;
    end else if (active) begin
      if (div_cnt == '0) begin
        div_cnt <= RELOAD;
        sclk    <= ~sclk;
        if (sclk) begin
          if (bit_cnt == 3'd0) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            mosi    <= shreg[6];
            shreg   <= {shreg[5:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_voice_cmd_tx.sv
// rtl/spi_voice_cmd_tx.sv - SPI master framing note-on/note-off voice commands with inter-byte gaps
module spi_voice_cmd_tx
  import midi_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_note_on,
  input  logic [7:0] i_cmd_voice_index,
  input  logic [6:0] i_cmd_midi_note,
  input  logic [6:0] i_cmd_velocity,
  output logic       o_SPI_sclk,
  output logic       o_SPI_mosi,
  output logic       o_SPI_cs_n,
  output logic       o_busy,
  output logic       o_done
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state;
  logic [7:0]    frame [4];
  logic [1:0]    byte_cnt;
  logic          note_on_q;
  logic [GW-1:0] gap_cnt;
  logic          byte_end, accept, advance, last_byte, start;
  logic [7:0]    start_data;

  assign accept     = (state == IDLE) && i_cmd_valid;
  assign last_byte  = (byte_cnt == last_index(note_on_q));
  assign advance    = ((state == SHIFT) && byte_end && (GAP_CYCLES == 0)) ||
                      ((state == GAP) && (gap_cnt == '0));
  assign start      = accept || (advance && !last_byte);
  // The header byte comes straight from the command so it reaches mosi one cycle after acceptance.
  assign start_data = accept ? (i_cmd_note_on ? NOTEON : NOTEOFF) : frame[byte_cnt + 2'd1];
  assign o_busy     = ~o_cmd_ready;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (i_clk),
    .reset     (i_reset),
    .start     (start),
    .data      (start_data),
    .sclk      (o_SPI_sclk),
    .mosi      (o_SPI_mosi),
    .byte_done (byte_end)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b1;
      o_SPI_cs_n  <= 1'b1;
      o_done      <= 1'b0;
      byte_cnt    <= 2'd0;
      gap_cnt     <= '0;
      note_on_q   <= 1'b0;
      for (int i = 0; i < 4; i++) frame[i] <= 8'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            frame[0]    <= i_cmd_note_on ? NOTEON : NOTEOFF;
            frame[1]    <= i_cmd_voice_index;
            frame[2]    <= {1'b0, i_cmd_midi_note};
            frame[3]    <= {1'b0, i_cmd_velocity};
            note_on_q   <= i_cmd_note_on;
            byte_cnt    <= 2'd0;
            o_cmd_ready <= 1'b0;
            o_SPI_cs_n  <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (byte_end) begin
            if (GAP_CYCLES != 0) begin
              gap_cnt <= GW'(GAP_CYCLES - 1);
              state   <= GAP;
            end else if (last_byte) begin
              o_done     <= 1'b1;
              o_SPI_cs_n <= 1'b1;
              state      <= FINISH;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (last_byte) begin
              o_done     <= 1'b1;
              o_SPI_cs_n <= 1'b1;
              state      <= FINISH;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              state    <= SHIFT;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        FINISH: begin
          o_cmd_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
